// File: rtl/axil_cmd_master_pkg.sv
// rtl/axil_cmd_master_pkg.sv - shared constants for the AXI4-Lite command master
package axil_cmd_master_pkg;

    localparam int CGRA_AXI_ADDR_WIDTH    = 32;
    localparam int CGRA_AXI_DATA_WIDTH    = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] TIMEOUT_RESP    = 2'b11;

endpackage

// File: rtl/axil_cmd_master_if.sv
// rtl/axil_cmd_master_if.sv - AXI4-Lite bus between the command master and the slave port
interface axil_cmd_master_if
    import axil_cmd_master_pkg::*;
#(
    parameter int ADDR_WIDTH = CGRA_AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH = CGRA_AXI_DATA_WIDTH
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_watchdog.sv
// rtl/axil_watchdog.sv - per-transaction cycle counter with clear/enable/expire
module axil_watchdog
    import axil_cmd_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;
    logic         at_last;

    assign at_last = (count == LAST);
    // Expire is only meaningful while the owner is counting.
    assign expire  = enable && at_last;

    // Count busy cycles; saturate at the limit so a late handshake cannot wrap it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !at_last) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/axil_cmd_master.sv
// rtl/axil_cmd_master.sv - single-outstanding AXI4-Lite master driven by a cmd/rsp stream
module axil_cmd_master
    import axil_cmd_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = CGRA_AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH     = CGRA_AXI_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    axil_cmd_master_if.master     axi
);
    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

    state_t state;
    logic   aw_done;
    logic   w_done;
    logic   accept;
    logic   busy;
    logic   expire;
    logic   aw_done_nxt;
    logic   w_done_nxt;
    logic   step;

    assign accept      = (state == IDLE) && cmd_valid && cmd_ready;
    assign busy        = (state == WR_REQ) || (state == WR_RESP) ||
                         (state == RD_REQ) || (state == RD_DATA);
    assign aw_done_nxt = aw_done || (axi.awvalid && axi.awready);
    assign w_done_nxt  = w_done  || (axi.wvalid  && axi.wready);

    // The handshake that lets the current busy state advance; it beats the watchdog.
    always_comb begin
        step = 1'b0;
        case (state)
            WR_REQ:  step = aw_done_nxt && w_done_nxt;
            WR_RESP: step = axi.bvalid;
            RD_REQ:  step = axi.arready;
            RD_DATA: step = axi.rvalid;
            default: step = 1'b0;
        endcase
    end

    axil_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (accept),
        .enable (busy),
        .expire (expire)
    );

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= AXI_RESP_OKAY;
            rsp_timeout <= 1'b0;
            axi.awaddr  <= '0;
            axi.awvalid <= 1'b0;
            axi.wdata   <= '0;
            axi.wvalid  <= 1'b0;
            axi.bready  <= 1'b0;
            axi.araddr  <= '0;
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b0;
        end else if (expire && !step) begin
            // Abort: drop every AXI handshake output and report a timeout.
            axi.awvalid <= 1'b0;
            axi.wvalid  <= 1'b0;
            axi.bready  <= 1'b0;
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_resp    <= TIMEOUT_RESP;
            rsp_timeout <= 1'b1;
            state       <= RSP;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        if (cmd_write) begin
                            axi.awaddr  <= cmd_addr;
                            axi.wdata   <= cmd_wdata;
                            axi.awvalid <= 1'b1;
                            axi.wvalid  <= 1'b1;
                            state       <= WR_REQ;
                        end else begin
                            axi.araddr  <= cmd_addr;
                            axi.arvalid <= 1'b1;
                            state       <= RD_REQ;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (step) begin
                        axi.awvalid <= 1'b0;
                        axi.wvalid  <= 1'b0;
                        axi.bready  <= 1'b1;
                        state       <= WR_RESP;
                    end else begin
                        if (axi.awvalid && axi.awready) begin
                            axi.awvalid <= 1'b0;
                            aw_done     <= 1'b1;
                        end
                        if (axi.wvalid && axi.wready) begin
                            axi.wvalid <= 1'b0;
                            w_done     <= 1'b1;
                        end
                    end
                end
                WR_RESP: begin
                    if (step) begin
                        axi.bready  <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_resp    <= axi.bresp;
                        rsp_timeout <= 1'b0;
                        state       <= RSP;
                    end
                end
                RD_REQ: begin
                    if (step) begin
                        axi.arvalid <= 1'b0;
                        axi.rready  <= 1'b1;
                        state       <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (step) begin
                        axi.rready  <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= axi.rdata;
                        rsp_resp    <= axi.rresp;
                        rsp_timeout <= 1'b0;
                        state       <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_rdata   <= '0;
                        rsp_resp    <= AXI_RESP_OKAY;
                        rsp_timeout <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/axil_cmd_master.md
# axil_cmd_master

Synthesizable AXI4-Lite master that drives Garnet's `axi4_slave_*` configuration port from a simple command/response stream. It replaces the behavioural AXI-Lite driver in the test harness. It is the stage directly upstream of Garnet's AXI4-Lite slave, fed by a host CPU shim or a test sequencer. It allows one transaction in flight, enforces the AXI handshake rules, and has a watchdog so a hung slave cannot stall the host.

## Interface
Parameters:
- `ADDR_WIDTH`, default `CGRA_AXI_ADDR_WIDTH`: AXI address width.
- `DATA_WIDTH`, default `CGRA_AXI_DATA_WIDTH`: AXI data width.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit per transaction, in cycles. Must be ≥ 2.

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted this cycle when high together with `cmd_valid`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH  byte address.
- `cmd_wdata`  in  DATA_WIDTH  write data (ignored for reads).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes.
- `rsp_resp`  out  2  captured BRESP/RRESP, or 2'b11 on timeout.
- `rsp_timeout`  out  1  transaction aborted by the watchdog.
- `awaddr`, `awvalid`, `awready`, `wdata`, `wvalid`, `wready`, `bresp`, `bvalid`, `bready`, `araddr`, `arvalid`, `arready`, `rdata`, `rresp`, `rvalid`, `rready`: AXI4-Lite master side, with widths and directions mirroring Garnet's `axi4_slave_*` ports.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - `cmd_ready` = 1.
  - Accepting a write latches addr/data and goes to WR_REQ.
  - Accepting a read latches addr and goes to RD_REQ.
- WR_REQ:
  - `awvalid` and `wvalid` rise together.
  - Each drops independently on its own handshake; a per-channel done flag records it.
  - Go to WR_RESP when both are done, including the case where both complete in the same cycle.
- WR_RESP:
  - `bready` = 1.
  - On `bvalid`, capture `bresp`, set `rsp_rdata` = 0, and go to RSP.
- RD_REQ:
  - `arvalid` = 1.
  - On `arready`, go to RD_DATA.
- RD_DATA:
  - `rready` = 1.
  - On `rvalid`, capture `rdata`/`rresp` and go to RSP.
- RSP:
  - `rsp_valid` = 1; response fields stay stable until `rsp_ready`.
  - On `rsp_ready`, return to IDLE. A new command is accepted no earlier than the following cycle.
- Watchdog:
  - The counter clears on command accept and increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - When the count reaches `TIMEOUT_CYCLES`-1, all AXI valid/ready outputs drop, `rsp_timeout` = 1, `rsp_resp` = 2'b11, `rsp_rdata` = 0, and the FSM goes to RSP.
  - A handshake in the same cycle as the timeout wins: the normal transition happens and there is no timeout.
  - A timeout abort violates AXI valid-hold by design; it is a debug/recovery path, and the slave is then reset externally.
- Unused byte strobes are not generated; Garnet's slave port has no WSTRB.

## Timing
- All outputs are registered.
- Reset values (asserted asynchronously the instant `reset_n` falls):
  - all valid/ready outputs 0;
  - `rsp_*` 0;
  - `awaddr`/`wdata`/`araddr` 0;
  - state IDLE.
- `cmd_ready` is 0 during reset and rises 1 cycle after `reset_n` deasserts.
- Reset mid-transaction abandons it silently; no response is produced.
- Minimum write latency, with zero-wait slave:
  - cmd accepted at cycle 0;
  - `awvalid`/`wvalid` high at cycle 1, handshake at cycle 1;
  - `bready` high at cycle 2, with `bvalid` at cycle 2;
  - `rsp_valid` at cycle 3.
- Minimum read latency: accept at cycle 0, `arvalid` at cycle 1, `rready` at cycle 2, `rsp_valid` at cycle 3.
- Throughput with `rsp_ready` tied 1: one transaction every 5 cycles.
- Valid outputs never depend combinationally on ready inputs.

## Structure
- Shared package (`global_buffer_param` or a new `axil_pkg`):
  - AXI response constants: OKAY 2'b00, SLVERR 2'b10, and TIMEOUT_RESP 2'b11.
  - the default timeout value.
- The state enum is local to the module.
- One natural sub-module: `axil_watchdog`, a counter with clear/enable/expire.
- Everything else stays flat.

## Test plan
- Write: addr 0x1000, data 0xDEADBEEF, zero-wait slave -> `awaddr`=0x1000, `wdata`=0xDEADBEEF; `rsp_valid` at cycle 3 with `rsp_resp`=0 and `rsp_timeout`=0.
- Slave asserts `wready` 4 cycles before `awready` -> `wvalid` drops after its handshake, `awvalid` is held until its own; exactly one of each handshake occurs.
- Read: addr 0x2004, slave returns 0x12345678 with `rresp`=2'b10 after a 3-cycle `rvalid` delay -> `rsp_rdata`=0x12345678, `rsp_resp`=2'b10.
- `rsp_ready` held low 10 cycles -> `rsp_valid` and data stable throughout; `cmd_ready`=0 until 1 cycle after consumption.
- Slave never asserts `arready`, with `TIMEOUT_CYCLES`=16 -> `arvalid` drops after 16 cycles; `rsp_timeout`=1, `rsp_resp`=2'b11.
- `reset_n` pulsed low during WR_RESP -> all outputs 0 immediately, no response emitted, and the next command completes normally.
